// File: rtl/uart_rx_cfg.sv
// uart_rx_cfg: oversampled UART receiver with configurable word length,
// parity and stop bits. It uses a two-flop input synchroniser, a 3-sample
// majority vote per bit and false-start rejection. Received words go into a
// holding register that the consumer releases with rd.
module uart_rx_cfg #(
  parameter int DBIT       = 8,
  parameter int OVERSAMPLE = 16,
  parameter int PARITY_EN  = 0,
  parameter int PARITY_ODD = 0,
  parameter int SB_BITS    = 1
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            rx,
  input  logic            s_tick,
  input  logic            rd,
  output logic [DBIT-1:0] dout,
  output logic            rx_valid,
  output logic            rx_done_tick,
  output logic            parity_err,
  output logic            frame_err,
  output logic            break_det,
  output logic            overrun
);
  localparam int SW = $clog2(OVERSAMPLE);
  // DBIT >= 5, so this width also covers the stop-bit index
  localparam int NW = $clog2(DBIT);

  typedef enum logic [2:0] {IDLE, START, DATA, PARITY, STOP, WAIT_HIGH} state_t;

  typedef struct packed {
    logic [DBIT-1:0] data;
    logic            perr;
    logic            ferr;
    logic            brk;
  } word_t;

  state_t          state_q, state_d;
  logic [SW-1:0]   s_q, s_d;
  logic [NW-1:0]   n_q, n_d;
  logic [DBIT-1:0] sh_q, sh_d;
  logic [1:0]      smp_q, smp_d;
  logic            par_q, par_d;    // received parity bit
  logic            ferr_q, ferr_d;  // a stop bit so far resolved low
  logic            sone_q, sone_d;  // a stop bit so far resolved high
  logic            rx_m, rx_s;
  word_t           hold_q, new_w;
  logic            valid_q, ovr_q;
  logic            last_tick, bit_v, in_bit;

  // The third sample is the live rx_s on the resolving tick
  assign last_tick = s_tick && (s_q == SW'(OVERSAMPLE-1));
  assign bit_v     = (smp_q[0] & smp_q[1]) | (smp_q[0] & rx_s) | (smp_q[1] & rx_s);
  assign in_bit    = (state_q == DATA) || (state_q == PARITY) || (state_q == STOP);

  // Two-flop synchroniser; idles high so reset does not look like a start bit
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      rx_m <= 1'b1;
      rx_s <= 1'b1;
    end else begin
      rx_m <= rx;
      rx_s <= rx_m;
    end
  end

  // FSM state and bit-timing registers
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= IDLE;
      s_q     <= '0;
      n_q     <= '0;
      sh_q    <= '0;
      smp_q   <= '0;
      par_q   <= 1'b0;
      ferr_q  <= 1'b0;
      sone_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      s_q     <= s_d;
      n_q     <= n_d;
      sh_q    <= sh_d;
      smp_q   <= smp_d;
      par_q   <= par_d;
      ferr_q  <= ferr_d;
      sone_q  <= sone_d;
    end
  end

  // Next-state and datapath updates; nothing advances without s_tick
  always_comb begin
    state_d = state_q;
    s_d     = s_q;
    n_d     = n_q;
    sh_d    = sh_q;
    smp_d   = smp_q;
    par_d   = par_q;
    ferr_d  = ferr_q;
    sone_d  = sone_q;
    if (s_tick && in_bit) begin
      s_d = s_q + 1'b1;
      if (s_q == SW'(OVERSAMPLE-3)) smp_d[0] = rx_s;
      if (s_q == SW'(OVERSAMPLE-2)) smp_d[1] = rx_s;
      if (last_tick) s_d = '0;
    end
    case (state_q)
      IDLE: if (!rx_s) begin
        state_d = START;
        s_d     = '0;
      end
      START: if (s_tick) begin
        if (s_q == SW'(OVERSAMPLE/2-1)) begin
          if (!rx_s) begin
            state_d = DATA;
            s_d     = '0;
            n_d     = '0;
            par_d   = 1'b0;
            ferr_d  = 1'b0;
            sone_d  = 1'b0;
          end else begin
            state_d = IDLE;
          end
        end else begin
          s_d = s_q + 1'b1;
        end
      end
      DATA: if (last_tick) begin
        sh_d = {bit_v, sh_q[DBIT-1:1]};
        if (n_q == NW'(DBIT-1)) begin
          n_d     = '0;
          state_d = (PARITY_EN != 0) ? PARITY : STOP;
        end else begin
          n_d = n_q + 1'b1;
        end
      end
      PARITY: if (last_tick) begin
        par_d   = bit_v;
        state_d = STOP;
      end
      STOP: if (last_tick) begin
        ferr_d = ferr_q | ~bit_v;
        sone_d = sone_q | bit_v;
        if (n_q == NW'(SB_BITS-1)) begin
          n_d     = '0;
          // a framing error may mean a held-low line; wait for it to rise
          state_d = (ferr_q | ~bit_v) ? WAIT_HIGH : IDLE;
        end else begin
          n_d = n_q + 1'b1;
        end
      end
      WAIT_HIGH: if (rx_s) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Completion strobe and the word/status to be captured with it
  always_comb begin
    rx_done_tick = (state_q == STOP) && last_tick && (n_q == NW'(SB_BITS-1));
    new_w.data   = sh_q;
    new_w.perr   = (PARITY_EN != 0) && ((^sh_q ^ par_q) != (PARITY_ODD != 0));
    new_w.ferr   = ferr_q | ~bit_v;
    new_w.brk    = (sh_q == '0) && !par_q && !(sone_q | bit_v);
  end

  // Holding register with valid/read handshake and sticky overrun
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      hold_q  <= '0;
      valid_q <= 1'b0;
      ovr_q   <= 1'b0;
    end else if (rx_done_tick) begin
      hold_q  <= new_w;
      valid_q <= 1'b1;
      ovr_q   <= rd ? 1'b0 : (ovr_q | valid_q);
    end else if (rd && valid_q) begin
      hold_q.perr <= 1'b0;
      hold_q.ferr <= 1'b0;
      hold_q.brk  <= 1'b0;
      valid_q     <= 1'b0;
      ovr_q       <= 1'b0;
    end
  end

  assign dout       = hold_q.data;
  assign parity_err = hold_q.perr;
  assign frame_err  = hold_q.ferr;
  assign break_det  = hold_q.brk;
  assign rx_valid   = valid_q;
  assign overrun    = ovr_q;
endmodule

// File: tb/tb_uart_rx_cfg.sv
// tb_uart_rx_cfg: directed corner cases plus a randomized run. Expected
// words come from the frame contents and a small holding-register model.
module tb_uart_rx_cfg;
  localparam int OS = 16;

  logic clk = 0, reset = 1, rx = 1, rx2 = 1, s_tick = 0;
  logic rd_cmd = 0, rd2 = 0, auto_rd = 0, rd;
  logic [7:0] dout;
  logic       rx_valid, done, perr, ferr, brk, ovr;
  logic [6:0] dout2;
  logic       rx_valid2, done2, perr2, ferr2, brk2, ovr2;
  logic [1:0] cnt = 0;
  int tk = 0, done_cnt = 0, done2_cnt = 0, done_tk = 0;
  int checks = 0, errors = 0;

  assign rd = rd_cmd | (auto_rd & done);

  uart_rx_cfg u0 (
    .clk(clk), .reset(reset), .rx(rx), .s_tick(s_tick), .rd(rd),
    .dout(dout), .rx_valid(rx_valid), .rx_done_tick(done),
    .parity_err(perr), .frame_err(ferr), .break_det(brk), .overrun(ovr)
  );

  uart_rx_cfg #(.DBIT(7), .PARITY_EN(1), .PARITY_ODD(0)) u1 (
    .clk(clk), .reset(reset), .rx(rx2), .s_tick(s_tick), .rd(rd2),
    .dout(dout2), .rx_valid(rx_valid2), .rx_done_tick(done2),
    .parity_err(perr2), .frame_err(ferr2), .break_det(brk2), .overrun(ovr2)
  );

  always #5 clk = ~clk;

  // tick every 4 clk; tk counts ticks consumed by the DUT
  always @(posedge clk) begin
    cnt    <= cnt + 2'd1;
    s_tick <= (cnt == 2'd3);
    if (s_tick) tk <= tk + 1;
  end

  // completion monitor, mid-cycle
  always @(negedge clk) begin
    if (done) begin
      done_cnt <= done_cnt + 1;
      done_tk  <= tk + 1;
    end
    if (done2) done2_cnt <= done2_cnt + 1;
  end

  initial begin
    #3ms;
    $display("FAIL watchdog got timeout exp finish");
    $fatal(1);
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %0h exp %0h", tag, got, exp);
    end
  endtask

  task automatic wait_tick();
    do @(posedge clk); while (!s_tick);
    #1;
  endtask

  task automatic drive(input int sel, input logic v);
    if (sel == 0) rx = v; else rx2 = v;
  endtask

  task automatic idle_ticks(input int sel, input int n);
    drive(sel, 1'b1);
    for (int i = 0; i < n; i++) wait_tick();
  endtask

  // bits[0] is the start bit; gbit selects a bit whose 7th tick is inverted
  task automatic send(input int sel, input logic [15:0] bits, input int nb, input int gbit,
                      output int t0);
    wait_tick();
    t0 = tk;
    for (int b = 0; b < nb; b++)
      for (int t = 1; t <= OS; t++) begin
        drive(sel, bits[b] ^ ((b == gbit) && (t == 7)));
        wait_tick();
      end
    drive(sel, 1'b1);
    repeat (3) @(posedge clk);
    #1;
  endtask

  task automatic read(input int sel);
    @(posedge clk); #1;
    if (sel == 0) rd_cmd = 1; else rd2 = 1;
    @(posedge clk); #1;
    rd_cmd = 0; rd2 = 0;
  endtask

  function automatic logic [15:0] f8(input logic [7:0] d, input logic stp);
    return {6'b0, stp, d, 1'b0};
  endfunction

  task automatic chk_zero(input string tag);
    chk({tag, "_dout"}, dout, 0);
    chk({tag, "_valid"}, rx_valid, 0);
    chk({tag, "_done"}, done, 0);
    chk({tag, "_perr"}, perr, 0);
    chk({tag, "_ferr"}, ferr, 0);
    chk({tag, "_brk"}, brk, 0);
    chk({tag, "_ovr"}, ovr, 0);
  endtask

  initial begin
    int t0, dc;
    logic [7:0] d, md;
    logic mv, mo;

    repeat (4) @(posedge clk);
    #1;
    chk_zero("rst");
    reset = 0;
    idle_ticks(0, 4);

    // basic 8N1 word and latency from start edge
    dc = done_cnt;
    send(0, f8(8'hA5, 1'b1), 10, -1, t0);
    chk("a5_cnt", done_cnt - dc, 1);
    chk("a5_lat", done_tk - t0, 152);
    chk("a5_dout", dout, 8'hA5);
    chk("a5_valid", rx_valid, 1);
    chk("a5_perr", perr, 0);
    chk("a5_ferr", ferr, 0);
    chk("a5_brk", brk, 0);
    read(0);
    chk("a5_rd_valid", rx_valid, 0);

    // 7E1 on the second instance: 0x41 has two ones
    send(1, {6'b0, 1'b1, 1'b0, 7'h41, 1'b0}, 10, -1, t0);
    chk("p0_cnt", done2_cnt, 1);
    chk("p0_perr", perr2, 0);
    chk("p0_dout", dout2, 7'h41);
    chk("p0_valid", rx_valid2, 1);
    read(1);
    send(1, {6'b0, 1'b1, 1'b1, 7'h41, 1'b0}, 10, -1, t0);
    chk("p1_perr", perr2, 1);
    chk("p1_dout", dout2, 7'h41);
    chk("p1_ferr", ferr2, 0);
    read(1);
    chk("p1_rd_perr", perr2, 0);

    // stop bit low
    send(0, f8(8'h3C, 1'b0), 10, -1, t0);
    chk("fe_ferr", ferr, 1);
    chk("fe_brk", brk, 0);
    chk("fe_dout", dout, 8'h3C);
    idle_ticks(0, 4);
    read(0);
    chk("fe_rd_ferr", ferr, 0);

    // held-low line: exactly one break completion
    dc = done_cnt;
    wait_tick();
    drive(0, 1'b0);
    for (int i = 0; i < 3 * 10 * OS; i++) wait_tick();
    chk("brk_cnt", done_cnt - dc, 1);
    chk("brk_dout", dout, 0);
    chk("brk_brk", brk, 1);
    chk("brk_ferr", ferr, 1);
    idle_ticks(0, 200);
    chk("brk_cnt_hi", done_cnt - dc, 1);
    read(0);

    // false start then a glitch inside data bit 3
    dc = done_cnt;
    wait_tick();
    drive(0, 1'b0);
    for (int i = 0; i < 4; i++) wait_tick();
    idle_ticks(0, 200);
    chk("fs_cnt", done_cnt - dc, 0);
    send(0, f8(8'h55, 1'b1), 10, 4, t0);
    chk("gl_cnt", done_cnt - dc, 1);
    chk("gl_dout", dout, 8'h55);
    chk("gl_ferr", ferr, 0);
    read(0);

    // overrun, then read coincident with completion
    send(0, f8(8'h11, 1'b1), 10, -1, t0);
    chk("ov1_ovr", ovr, 0);
    send(0, f8(8'h22, 1'b1), 10, -1, t0);
    chk("ov2_ovr", ovr, 1);
    chk("ov2_dout", dout, 8'h22);
    chk("ov2_valid", rx_valid, 1);
    auto_rd = 1;
    send(0, f8(8'h33, 1'b1), 10, -1, t0);
    auto_rd = 0;
    chk("ovc_ovr", ovr, 0);
    chk("ovc_valid", rx_valid, 1);
    chk("ovc_dout", dout, 8'h33);
    read(0);
    chk("ovc_rd_valid", rx_valid, 0);

    // reset in the middle of a frame
    send(0, f8(8'h5A, 1'b1), 10, -1, t0);
    chk("mr_pre_valid", rx_valid, 1);
    wait_tick();
    drive(0, 1'b0);
    for (int i = 0; i < 40; i++) wait_tick();
    reset = 1;
    repeat (2) @(posedge clk);
    #1;
    chk_zero("mr");
    drive(0, 1'b1);
    reset = 0;
    idle_ticks(0, 20);
    dc = done_cnt;
    send(0, f8(8'h7E, 1'b1), 10, -1, t0);
    chk("mr_cnt", done_cnt - dc, 1);
    chk("mr_dout", dout, 8'h7E);
    chk("mr_valid", rx_valid, 1);
    read(0);

    // randomized words against the holding-register model
    mv = 0; mo = 0; md = 0;
    for (int i = 0; i < 20; i++) begin
      idle_ticks(0, $urandom_range(0, 8));
      d = 8'($urandom);
      send(0, f8(d, 1'b1), 10, -1, t0);
      mo = mo | mv;
      md = d;
      mv = 1;
      chk("rnd_dout", dout, md);
      chk("rnd_valid", rx_valid, mv);
      chk("rnd_ovr", ovr, mo);
      if ($urandom_range(0, 1) == 1) begin
        read(0);
        mv = 0;
        mo = 0;
        chk("rnd_rd_valid", rx_valid, mv);
        chk("rnd_rd_ovr", ovr, mo);
      end
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule

// File: doc/uart_rx_cfg.md
# uart_rx_cfg

Parametrised UART receiver, successor to the fixed 8N1 receiver in the tic-tac-toe serial link. Adds configurable word length, optional even/odd parity, 1 or 2 stop bits, an input synchroniser, 3-sample majority voting, and false-start rejection. Received words land in a holding register with a valid/read handshake. Parity, framing, overrun and line-break status are reported per word. It is driven by the shared baud-rate tick generator (`s_tick`) and feeds the game's command decoder.

## Interface
- `DBIT`, 8: data bits per frame, legal 5..9.
- `OVERSAMPLE`, 16: `s_tick` pulses per bit period, even, legal 8..32.
- `PARITY_EN`, 0: 1 = a parity bit follows the data.
- `PARITY_ODD`, 0: 0 = even parity, 1 = odd parity; ignored when `PARITY_EN`=0.
- `SB_BITS`, 1: number of stop bits, 1 or 2.
- `clk`  in  1  system clock.
- `reset`  in  1  asynchronous, active-high reset.
- `rx`  in  1  serial line, asynchronous, idle high.
- `s_tick`  in  1  oversampling tick, one `clk` wide.
- `rd`  in  1  consumer read strobe; clears `rx_valid` and the status flags.
- `dout`  out  DBIT  last received word, LSB = first bit received.
- `rx_valid`  out  1  holding register contains an unread word.
- `rx_done_tick`  out  1  one-`clk` pulse on each completed frame, good or bad.
- `parity_err`  out  1  parity mismatch on the word in `dout`.
- `frame_err`  out  1  a stop bit was sampled low on the word in `dout`.
- `break_det`  out  1  the frame was all zeros, including parity and stop bits.
- `overrun`  out  1  sticky; an unread word was overwritten.

## Operation
- `rx` passes through 2 flops, both resetting to 1, giving `rx_s`; all decisions use `rx_s`.
- FSM states: IDLE, START, DATA, PARITY, STOP, WAIT_HIGH.
- IDLE: when `rx_s`=0, go to START and clear the tick counter `s`.
- START: count `s_tick`. At `s`=`OVERSAMPLE/2-1`:
  - if `rx_s`=0, go to DATA with `s`=0 and bit index `n`=0;
  - otherwise it is a false start: return to IDLE with no output activity.
- Bit sampling (DATA, PARITY, STOP): `s` counts 0..`OVERSAMPLE-1`. `rx_s` is captured on the ticks where `s`=`OVERSAMPLE-3`, `-2` and `-1`. The bit value is the majority of the 3 samples and is resolved on the tick where `s`=`OVERSAMPLE-1`, after which `s` resets to 0.
- DATA: shift the resolved bit into the MSB of a DBIT-wide shift register (LSB-first line order). After bit `DBIT-1`, go to PARITY if `PARITY_EN`, else STOP.
- PARITY: resolve one bit, then go to STOP.
  - Even parity: error if XOR(data, parity bit)=1.
  - Odd parity: error if XOR(data, parity bit)=0.
- STOP: resolve `SB_BITS` bits. Any stop bit resolved 0 sets the frame error. After the last stop bit the frame completes on that same tick.
- Frame completion:
  - `rx_done_tick`=1;
  - `dout`, `parity_err`, `frame_err`, `break_det` are loaded;
  - `rx_valid`=1.
- Break: data=0, parity bit (if any)=0 and all stop bits=0. `break_det` and `frame_err` are both set.
- After completing a frame with a frame error, go to WAIT_HIGH. Stay there until `rx_s`=1, then go to IDLE, so a held-low line does not retrigger. Otherwise go directly to IDLE.
- Overrun: a completion while `rx_valid`=1 and `rd`=0 overwrites `dout` and the status, and sets `overrun`.
- `rd`=1: clears `rx_valid`, `overrun`, `parity_err`, `frame_err`, `break_det` next cycle. `rd` while `rx_valid`=0 has no effect.
- `rd` coincident with a completion: the new word is loaded, `rx_valid` stays 1, `overrun` is not set, and the previous `overrun` is cleared.
- `s_tick` absent: FSM and counters hold.

## Timing
- Reset (asynchronous): FSM to IDLE; `s`, `n`, shift register to 0; synchroniser to 1. All outputs 0: `dout`=0, `rx_valid`, `rx_done_tick`, `parity_err`, `frame_err`, `break_det`, `overrun`=0.
- Reset mid-frame aborts the frame with no completion. Reception resumes at the next falling edge after release.
- `rx` to `rx_s`: 2 `clk`.
- `rx_done_tick` is combinational with the completing `s_tick` cycle.
- `dout`, `rx_valid` and the status flags are registered and valid the `clk` after `rx_done_tick`.
- Completion occurs `OVERSAMPLE/2 + OVERSAMPLE*(DBIT+PARITY_EN+SB_BITS)` ticks after `rx_s` falls. With defaults (8N1, `OVERSAMPLE`=16) this is 152 ticks.
- Any counter value not covered above is unreachable; there is no wrap-around path.

## Test plan
- Defaults, `s_tick` every 4 `clk`, send 0xA5 8N1:
  - one `rx_done_tick`;
  - `dout`=0xA5, `rx_valid`=1, all error flags 0;
  - `rd` pulse → `rx_valid`=0.
- `DBIT`=7, `PARITY_EN`=1, `PARITY_ODD`=0:
  - send 0x41 with parity bit 0 → `parity_err`=0;
  - send 0x41 with parity bit 1 → `parity_err`=1, `dout`=0x41.
- Defaults, send 0x3C with the stop bit low → `frame_err`=1, `break_det`=0.
- Hold `rx` low for 3 frame times → exactly one completion with `dout`=0, `break_det`=1, `frame_err`=1. No further completion until `rx` returns high.
- Glitches:
  - 4-tick low pulse on an idle line → no completion, FSM back in IDLE;
  - a 1-tick inverted glitch at `s`=`OVERSAMPLE-2` inside a data bit → majority vote gives the correct 0x55.
- Send 0x11 then 0x22 without `rd` → `overrun`=1, `dout`=0x22. Repeat with `rd` coincident with the second completion → `overrun`=0, `rx_valid`=1. Also assert `reset` mid-frame → all outputs 0, next frame 0x7E received correctly.
